// File: rtl/mips_pkg.sv
// Shared processor definitions: instruction-memory geometry and the loader FSM encoding.
package mips_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_RUN  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/instr_loader.sv
// Instruction-feed receiver: writes a burst of words into imem from init_pc, then releases the core.
module instr_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] init_pc,
    input  logic              instr_we,
    input  logic [DATA_W-1:0] instr_feed,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_run,
    output logic [ADDR_W-1:0] core_start_pc,
    output logic [ADDR_W:0]   load_count,
    output logic              load_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              err_q, err_d;

    // addr_q doubles as the burst pointer: it only advances on a committed write,
    // and dropped overflow words leave it untouched.
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        run_d   = run_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            LD_IDLE, LD_RUN: begin
                if (instr_we) begin
                    state_d = LD_LOAD;
                    run_d   = 1'b0;
                    start_d = init_pc;
                    addr_d  = init_pc;
                    wdata_d = instr_feed;
                    we_d    = 1'b1;
                    cnt_d   = {{ADDR_W{1'b0}}, 1'b1};
                    err_d   = 1'b0;
                end
            end
            LD_LOAD: begin
                if (instr_we) begin
                    if (cnt_q == CNT_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        wdata_d = instr_feed;
                        we_d    = 1'b1;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = LD_RUN;
                    run_d   = 1'b1;
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LD_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            run_q   <= 1'b0;
            start_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            run_q   <= run_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign core_run      = run_q;
    assign core_start_pc = start_q;
    assign load_count    = cnt_q;
    assign load_err      = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-size instance and a DEPTH=4 instance for overflow.
module tb_instr_loader;
    import mips_pkg::*;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // default-size instance
    logic [9:0]  a_pc = '0;
    logic        a_in_we = 1'b0;
    logic [31:0] a_feed = '0;
    logic        a_we, a_run, a_err;
    logic [9:0]  a_addr, a_start;
    logic [31:0] a_wdata;
    logic [10:0] a_cnt;

    // DEPTH=4 instance
    logic [1:0]  b_pc = '0;
    logic        b_in_we = 1'b0;
    logic [31:0] b_feed = '0;
    logic        b_we, b_run, b_err;
    logic [1:0]  b_addr, b_start;
    logic [31:0] b_wdata;
    logic [2:0]  b_cnt;

    instr_loader dut_a (
        .clk(clk), .rst(rst), .init_pc(a_pc), .instr_we(a_in_we), .instr_feed(a_feed),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .core_run(a_run),
        .core_start_pc(a_start), .load_count(a_cnt), .load_err(a_err)
    );

    instr_loader #(.ADDR_W(2), .DATA_W(32)) dut_b (
        .clk(clk), .rst(rst), .init_pc(b_pc), .instr_we(b_in_we), .instr_feed(b_feed),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .core_run(b_run),
        .core_start_pc(b_start), .load_count(b_cnt), .load_err(b_err)
    );

    int tests = 0;
    int fails = 0;
    wr_t qa[$];
    wr_t qb[$];
    logic [31:0] wds [0:7];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && a_we) begin
            if (qa.size() == 0) begin
                check("a_unexpected_write", 64'(a_addr), 64'h3ff_ffff);
            end else begin
                wr_t e;
                e = qa.pop_front();
                check("a_wr_addr", 64'(a_addr), 64'(e.a));
                check("a_wr_data", 64'(a_wdata), 64'(e.d));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b_we) begin
            if (qb.size() == 0) begin
                check("b_unexpected_write", 64'(b_addr), 64'hff);
            end else begin
                wr_t e;
                e = qb.pop_front();
                check("b_wr_addr", 64'(b_addr), 64'(e.a));
                check("b_wr_data", 64'(b_wdata), 64'(e.d));
            end
        end
    end

    // Drive n words into dut_a starting at base; toggle scrambles init_pc after the first word.
    task automatic burst_a(input logic [9:0] base, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a_in_we = 1'b1;
            a_feed  = wds[i];
            a_pc    = (toggle && i > 0) ? 10'(base + 10'(37 * i)) : base;
            qa.push_back('{a: 10'(base + 10'(i)), d: wds[i]});
        end
        @(negedge clk);
        a_in_we = 1'b0;
        a_pc    = 10'h155;
    endtask

    task automatic check_a_zero(string tag);
        check({tag, "_we"},    64'(a_we),    0);
        check({tag, "_addr"},  64'(a_addr),  0);
        check({tag, "_wdata"}, 64'(a_wdata), 0);
        check({tag, "_run"},   64'(a_run),   0);
        check({tag, "_start"}, 64'(a_start), 0);
        check({tag, "_cnt"},   64'(a_cnt),   0);
        check({tag, "_err"},   64'(a_err),   0);
    endtask

    initial begin
        wds[0] = 32'h20080005; wds[1] = 32'h20090003; wds[2] = 32'h01095020;
        wds[3] = 32'hAC0A0004; wds[4] = 32'h8C0B0004; wds[5] = 32'h1000FFFF;
        wds[6] = 32'h00000000; wds[7] = 32'hDEADBEEF;

        #12;
        check_a_zero("reset");
        check("reset_b_cnt", 64'(b_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // base 0, three words
        burst_a(10'd0, 3, 1'b0);
        check("t1_cnt", 64'(a_cnt), 3);
        check("t1_err", 64'(a_err), 0);
        check("t1_run_before", 64'(a_run), 0);
        @(negedge clk);
        check("t1_run_after", 64'(a_run), 1);
        check("t1_start", 64'(a_start), 0);

        // wrap from the top of memory, entered as a reload from LD_RUN
        burst_a(10'd1022, 4, 1'b0);
        check("t2_cnt", 64'(a_cnt), 4);
        @(negedge clk);
        check("t2_run", 64'(a_run), 1);
        check("t2_start", 64'(a_start), 1022);

        // reset after 2 of 5 words: the second word's write is killed before it is seen
        @(negedge clk);
        a_in_we = 1'b1; a_pc = 10'd40; a_feed = wds[0];
        qa.push_back('{a: 10'd40, d: wds[0]});
        @(negedge clk);
        a_feed = wds[1];
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_a_zero("midrst");
        @(negedge clk);
        a_in_we = 1'b0;
        check_a_zero("midrst_hold");
        @(negedge clk);
        rst = 1'b1;
        burst_a(10'd8, 2, 1'b0);
        check("t4_cnt", 64'(a_cnt), 2);
        @(negedge clk);
        check("t4_run", 64'(a_run), 1);

        // reload from LD_RUN at 16
        @(negedge clk);
        a_in_we = 1'b1; a_pc = 10'd16; a_feed = wds[3];
        qa.push_back('{a: 10'd16, d: wds[3]});
        @(negedge clk);
        check("t5_run_drop", 64'(a_run), 0);
        check("t5_cnt_restart", 64'(a_cnt), 1);
        check("t5_err", 64'(a_err), 0);
        check("t5_start", 64'(a_start), 16);
        a_pc = 10'd500; a_feed = wds[4];
        qa.push_back('{a: 10'd17, d: wds[4]});
        @(negedge clk);
        a_in_we = 1'b0;
        check("t5_cnt", 64'(a_cnt), 2);
        @(negedge clk);
        check("t5_run_rise", 64'(a_run), 1);

        // init_pc toggled mid-burst is ignored
        burst_a(10'd100, 5, 1'b1);
        check("t6_cnt", 64'(a_cnt), 5);
        check("t6_start", 64'(a_start), 100);

        // DEPTH=4 overflow: six words, only four writes
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check("b_err_before_ovf", 64'(b_err), 0);
            if (i == 5) begin
                check("b_err_5th", 64'(b_err), 1);
                check("b_cnt_5th", 64'(b_cnt), 4);
            end
            b_in_we = 1'b1; b_pc = 2'd0; b_feed = wds[i];
            if (i < 4) qb.push_back('{a: 10'(i), d: wds[i]});
        end
        @(negedge clk);
        b_in_we = 1'b0;
        check("b_err_end", 64'(b_err), 1);
        check("b_cnt_sat", 64'(b_cnt), 4);
        check("b_we_dropped", 64'(b_we), 0);
        @(negedge clk);
        check("b_run", 64'(b_run), 1);
        check("b_err_sticky", 64'(b_err), 1);

        // reload on the small instance clears the error
        @(negedge clk);
        b_in_we = 1'b1; b_pc = 2'd1; b_feed = wds[6];
        qb.push_back('{a: 10'd1, d: wds[6]});
        @(negedge clk);
        check("b_reload_err", 64'(b_err), 0);
        check("b_reload_cnt", 64'(b_cnt), 1);
        check("b_reload_run", 64'(b_run), 0);
        b_feed = wds[7];
        qb.push_back('{a: 10'd2, d: wds[7]});
        @(negedge clk);
        b_in_we = 1'b0;
        @(negedge clk);
        check("b_reload_run_rise", 64'(b_run), 1);
        check("b_reload_start", 64'(b_start), 1);

        repeat (3) @(negedge clk);
        check("qa_drained", 64'(qa.size()), 0);
        check("qb_drained", 64'(qb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
